// File: rtl/finger_chord_conditioner.sv
// Four-finger chord front end: polarity fix, two-flop synchroniser, per-bit
// debouncer and a settle-window FSM that emits one registered chord per change.
module finger_chord_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CHORD_WINDOW    = 2500000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] fingers_raw,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       D,
  output logic       chord_valid
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TMR_W = $clog2(CHORD_WINDOW + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CHORD_WINDOW - 1);

  typedef enum logic {IDLE, SETTLE} state_t;

  logic [3:0]       pressed;
  logic [3:0]       sync1;
  logic [3:0]       sync2;
  logic [3:0]       deb;
  logic [CNT_W-1:0] cnt [4];
  logic [3:0]       snap;
  logic [3:0]       out;
  logic [TMR_W-1:0] timer;
  state_t           state;

  // Everything downstream of this XOR works in the 1 = pressed domain.
  assign pressed = fingers_raw ^ {4{ACTIVE_LOW}};

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 4'b0000;
      sync2 <= 4'b0000;
    end else begin
      sync1 <= pressed;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      deb <= 4'b0000;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          deb[i] <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Any debounced change restarts the window, so staggered presses merge;
  // a press released inside the window expires with snap == out and is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      snap        <= 4'b0000;
      timer       <= '0;
      out         <= 4'b0000;
      chord_valid <= 1'b0;
    end else begin
      chord_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (deb != out) begin
            state <= SETTLE;
            snap  <= deb;
            timer <= '0;
          end
        end
        SETTLE: begin
          if (deb != snap) begin
            snap  <= deb;
            timer <= '0;
          end else if (timer == TMR_LAST) begin
            state <= IDLE;
            if (snap != out) begin
              out         <= snap;
              chord_valid <= 1'b1;
            end
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign {A, B, C, D} = out;

endmodule
